v_regfile_sb: RTL
=================

Name: v_regfile_sb

Overview:
- Vector register file with a write-back scoreboard; it is the consuming end of the vector write-back interface (vwb_en/vwb_addr/vwb_data).
- Holds NREG vector registers of VLEN bits and provides two combinational read ports to the vector decode/issue stage.
- Tracks destinations that have been issued but not yet written back, and raises a stall when a source or destination hazard exists.

Parameters:
- VLEN, 256, width of one vector register in bits (matches VREG_BUS).
- NREG, 32, number of vector registers.
- AW, 5, register address width; must equal clog2(NREG).

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- vwb_en_i  in  1  write-back enable from the write-back stage.
- vwb_addr_i  in  AW  write-back destination register.
- vwb_data_i  in  VLEN  write-back data.
- vrs1_en_i  in  1  source 1 valid for the instruction in decode.
- vrs1_addr_i  in  AW  source 1 register.
- vrs2_en_i  in  1  source 2 valid.
- vrs2_addr_i  in  AW  source 2 register.
- vrd_en_i  in  1  decode instruction writes a vector destination.
- vrd_addr_i  in  AW  destination register.
- vissue_i  in  1  decode instruction leaves decode this cycle; ignored while vstall_o=1.
- vrs1_data_o  out  VLEN  register[vrs1_addr_i].
- vrs2_data_o  out  VLEN  register[vrs2_addr_i].
- vstall_o  out  1  hazard; decode must hold.
- vbusy_o  out  NREG  scoreboard pending bits, for debug and drain.

Behaviour:
- Reset (asynchronous, rst_n=0): all NREG registers and all pending bits clear to 0. Outputs follow: vstall_o=0, vbusy_o=0, read data 0.
- Write: on a rising edge with vwb_en_i=1, reg[vwb_addr_i] <= vwb_data_i. There is no hardwired-zero register; v0 is writable.
- Read: combinational, so vrsN_data_o = reg[vrsN_addr_i] in the same cycle. Without bypass, a read of a register written in the same cycle returns the old value.
- Scoreboard, per register i:
  - Set condition: fire = vissue_i & ~vstall_o & vrd_en_i, with vrd_addr_i == i.
  - Clear condition: vwb_en_i, with vwb_addr_i == i.
  - Simultaneous set and clear of the same i: the set wins, because the new owner is still pending.
  - Clear of a bit that is not pending: no effect.
- Stall: vstall_o = (vrs1_en_i & pend[vrs1_addr_i]) | (vrs2_en_i & pend[vrs2_addr_i]) | (vrd_en_i & pend[vrd_addr_i]). The last term is the WAW check.
  - vstall_o is combinational from the pending bits and the decode inputs, with no added latency.
  - pend is the registered pending vector; it is read without same-cycle forwarding of the write-back clear, except under the optional feature below.
- Latency: an issued destination stalls dependent readers from the next cycle until the cycle after its write-back. With the optional feature, the stall lifts in the write-back cycle itself.
- Reset mid-operation: all pending state is lost. The pipeline is flushed by the same reset, so there is no recovery path.

Optional Feature:
- Macro: V_REGFILE_BYPASS_EN.
- Defined:
  - A same-cycle write is forwarded: if vwb_en_i=1 and vrsN_addr_i == vwb_addr_i, then vrsN_data_o = vwb_data_i.
  - The stall computation masks pend[vwb_addr_i] while vwb_en_i=1 (write-back clear forwarded), so the hazard releases in the write-back cycle.
- Undefined: read-old-value behaviour and the one-cycle-later stall release described above.

Decomposition:
- Shared vector defines file holds VLEN/VREG_BUS, VREG_ADDR_BUS, NREG, and the write-back selection encoding.
- One natural sub-module, v_scoreboard: pending bits, set/clear priority, stall logic.
- Storage and read muxes stay in the top module.

Test Plan:
- Reset then read: rst_n low, then high; read v5 and v31 -> both data outputs are 0; vstall_o=0; vbusy_o=0.
- Write then read: write v3=0xA5A5...A5; next cycle read rs1=v3, rs2=v0 -> rs1 returns 0xA5..A5, rs2 returns 0.
- RAW stall: issue with rd=v7, then rs1=v7 in decode -> vstall_o=1 until write-back of v7.
  - Without bypass, vstall_o falls the cycle after write-back.
  - With bypass, it falls in the write-back cycle, and vrs1_data_o equals the written value.
- Simultaneous set and clear: write-back of v9 in the same cycle as a new issue with rd=v9 -> vbusy_o[9] stays 1 and vstall_o=1 for a later reader of v9.
- WAW plus mid-operation reset: issue rd=v2, next decode rd=v2 -> vstall_o=1. Assert rst_n=0 mid-stall -> vbusy_o=0 and vstall_o=0 immediately, asynchronously.

Source files
------------

// File: rtl/v_regfile_sb_pkg.sv
// Shared vector defines: register width/count, address bus width and write-back source encoding.
// Build option V_REGFILE_BYPASS_EN (consumed by v_regfile_sb and v_scoreboard) enables same-cycle forwarding.
package v_regfile_sb_pkg;

  localparam int VREG_BUS      = 256;
  localparam int VREG_NUM      = 32;
  localparam int VREG_ADDR_BUS = 5;

  // Which unit drives the vector write-back bus
  typedef enum logic [1:0] {
    VWB_SEL_NONE = 2'd0,
    VWB_SEL_VALU = 2'd1,
    VWB_SEL_VLSU = 2'd2,
    VWB_SEL_VRED = 2'd3
  } vwb_sel_e;

endpackage

// File: rtl/v_scoreboard.sv
// Pending-destination scoreboard for the vector register file: set/clear priority and hazard stall.
// With V_REGFILE_BYPASS_EN defined the write-back clear is forwarded into the stall check.
module v_scoreboard
  import v_regfile_sb_pkg::*;
#(
  parameter int NREG = VREG_NUM,
  parameter int AW   = VREG_ADDR_BUS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic            rs1_en,
  input  logic [AW-1:0]   rs1_addr,
  input  logic            rs2_en,
  input  logic [AW-1:0]   rs2_addr,
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_addr,
  input  logic            issue,
  output logic            stall,
  output logic [NREG-1:0] busy
);

  logic [NREG-1:0] pend;
  logic [NREG-1:0] pend_view;
  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] clr_vec;
  logic            fire;

  always_comb begin
    clr_vec = '0;
    if (wb_en) clr_vec[wb_addr] = 1'b1;
  end

`ifdef V_REGFILE_BYPASS_EN
  assign pend_view = pend & ~clr_vec;
`else
  assign pend_view = pend;
`endif

  // The last term is the WAW check on the decode destination
  assign stall = (rs1_en & pend_view[rs1_addr]) |
                 (rs2_en & pend_view[rs2_addr]) |
                 (rd_en  & pend_view[rd_addr]);

  assign fire = issue & ~stall & rd_en;

  always_comb begin
    set_vec = '0;
    if (fire) set_vec[rd_addr] = 1'b1;
  end

  // Set is applied after clear so a new owner of the same register stays pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend <= '0;
    else        pend <= (pend & ~clr_vec) | set_vec;
  end

  assign busy = pend;

endmodule

// File: rtl/v_regfile_sb.sv
// Vector register file with two combinational read ports and a write-back scoreboard.
// V_REGFILE_BYPASS_EN forwards same-cycle write-back data to the read ports.
module v_regfile_sb
  import v_regfile_sb_pkg::*;
#(
  parameter int VLEN = VREG_BUS,
  parameter int NREG = VREG_NUM,
  parameter int AW   = VREG_ADDR_BUS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            vwb_en_i,
  input  logic [AW-1:0]   vwb_addr_i,
  input  logic [VLEN-1:0] vwb_data_i,
  input  logic            vrs1_en_i,
  input  logic [AW-1:0]   vrs1_addr_i,
  input  logic            vrs2_en_i,
  input  logic [AW-1:0]   vrs2_addr_i,
  input  logic            vrd_en_i,
  input  logic [AW-1:0]   vrd_addr_i,
  input  logic            vissue_i,
  output logic [VLEN-1:0] vrs1_data_o,
  output logic [VLEN-1:0] vrs2_data_o,
  output logic            vstall_o,
  output logic [NREG-1:0] vbusy_o
);

  logic [VLEN-1:0] regs [NREG];

  // v0 is an ordinary register; no hardwired zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (vwb_en_i) begin
      regs[vwb_addr_i] <= vwb_data_i;
    end
  end

  always_comb begin
    vrs1_data_o = regs[vrs1_addr_i];
    vrs2_data_o = regs[vrs2_addr_i];
`ifdef V_REGFILE_BYPASS_EN
    if (vwb_en_i && (vrs1_addr_i == vwb_addr_i)) vrs1_data_o = vwb_data_i;
    if (vwb_en_i && (vrs2_addr_i == vwb_addr_i)) vrs2_data_o = vwb_data_i;
`endif
  end

  v_scoreboard #(
    .NREG (NREG),
    .AW   (AW)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .wb_en    (vwb_en_i),
    .wb_addr  (vwb_addr_i),
    .rs1_en   (vrs1_en_i),
    .rs1_addr (vrs1_addr_i),
    .rs2_en   (vrs2_en_i),
    .rs2_addr (vrs2_addr_i),
    .rd_en    (vrd_en_i),
    .rd_addr  (vrd_addr_i),
    .issue    (vissue_i),
    .stall    (vstall_o),
    .busy     (vbusy_o)
  );

endmodule
